hart_dm_arbiter: RTL and testbench

Parametrised data-memory arbiter that lets NHARTS single-cycle harts share one data-memory port. Each hart presents its normal data-memory request (read/write, address, write data, funct3). The arbiter grants one hart at a time, latches that request, and drives it to the shared port. It returns the memory's ready/read data to the granted hart only. It sits between the per-hart data-memory ports and the shared data cache/memory in a multi-hart top.

---
 rtl/hart_arb_pkg.sv | 18 +
 rtl/hart_rr_picker.sv | 42 ++++
 rtl/hart_dm_arbiter.sv | 114 +++++++++++
 tb/tb_hart_dm_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hart_arb_pkg.sv
// Shared types and constants for the hart data-memory arbiter.
// Holds the arbiter state enum, funct3 width and default data width.
package hart_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int F3_W     = 3;
  localparam int XLEN_DEF = 32;

  // Grant index width, never narrower than one bit.
  function automatic int hid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hart_rr_picker.sv
// Winner selection among requesting harts; round-robin by default.
// Define HART_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module hart_rr_picker
  import hart_arb_pkg::*;
#(
  parameter  int NHARTS = 2,
  localparam int HID_W  = hid_w(NHARTS)
) (
  input  logic [NHARTS-1:0] i_req,
  input  logic [HID_W-1:0]  i_last,
  output logic [HID_W-1:0]  o_win,
  output logic              o_any
);

  assign o_any = |i_req;

`ifdef HART_ARB_FIXED_PRIO_EN
  logic w_unused_last;
  assign w_unused_last = ^i_last;

  // Lowest requesting index wins; descending scan lets it write last.
  always_comb begin
    o_win = '0;
    for (int k = NHARTS - 1; k >= 0; k--) begin
      if (i_req[k]) o_win = HID_W'(k);
    end
  end
`else
  int w_idx;

  // Search from last+1 upward; descending scan so the first hit wins.
  always_comb begin
    o_win = '0;
    w_idx = 0;
    for (int k = NHARTS; k >= 1; k--) begin
      w_idx = (int'(i_last) + k) % NHARTS;
      if (i_req[w_idx]) o_win = HID_W'(w_idx);
    end
  end
`endif

endmodule

// File: rtl/hart_dm_arbiter.sv
// Shares one data-memory port among NHARTS harts, one access at a time.
// Option macro: HART_ARB_FIXED_PRIO_EN (fixed priority instead of RR).
module hart_dm_arbiter
  import hart_arb_pkg::*;
#(
  parameter  int NHARTS = 2,
  parameter  int XLEN   = XLEN_DEF,
  localparam int HID_W  = hid_w(NHARTS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NHARTS-1:0]      i_req_read,
  input  logic [NHARTS-1:0]      i_req_wen,
  input  logic [NHARTS*XLEN-1:0] i_req_addr,
  input  logic [NHARTS*XLEN-1:0] i_req_wdata,
  input  logic [NHARTS*F3_W-1:0] i_req_f3,
  output logic [NHARTS-1:0]      o_rsp_ready,
  output logic [XLEN-1:0]        o_rsp_rdata,
  output logic [XLEN-1:0]        o_DM_Addr,
  output logic [XLEN-1:0]        o_DM_WriteData,
  output logic [F3_W-1:0]        o_DM_f3,
  output logic                   o_DM_MemRead,
  output logic                   o_DM_Wen,
  input  logic                   i_DM_data_ready,
  input  logic [XLEN-1:0]        i_DM_ReadData
);

  arb_state_t r_state;
  arb_state_t w_next;

  logic [HID_W-1:0]  r_last;
  logic [HID_W-1:0]  r_grant;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [F3_W-1:0]   r_f3;
  logic              r_read;
  logic              r_wen;

  logic [NHARTS-1:0] w_req;
  logic [NHARTS-1:0] w_sel;
  logic [NHARTS-1:0] w_gsel;
  logic [HID_W-1:0]  w_win;
  logic              w_any;
  logic              w_sel_read;
  logic              w_sel_wen;
  logic              w_busy;

  assign w_req      = i_req_read | i_req_wen;
  assign w_sel      = NHARTS'(1) << w_win;
  assign w_gsel     = NHARTS'(1) << r_grant;
  assign w_sel_read = |(i_req_read & w_sel);
  assign w_sel_wen  = |(i_req_wen & w_sel);

  hart_rr_picker #(
    .NHARTS (NHARTS)
  ) u_pick (
    .i_req  (w_req),
    .i_last (r_last),
    .o_win  (w_win),
    .o_any  (w_any)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ARB_IDLE;
    else       r_state <= w_next;
  end

  // Grant on any request; release on memory completion.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ARB_IDLE: if (w_any)           w_next = ARB_BUSY;
      ARB_BUSY: if (i_DM_data_ready) w_next = ARB_IDLE;
      default:                       w_next = ARB_IDLE;
    endcase
  end

  // Latch the winner's request; advance the pointer on completion.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last  <= HID_W'(NHARTS - 1);
      r_grant <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_f3    <= '0;
      r_read  <= 1'b0;
      r_wen   <= 1'b0;
    end else if (r_state == ARB_IDLE && w_any) begin
      r_grant <= w_win;
      r_addr  <= i_req_addr[int'(w_win)*XLEN +: XLEN];
      r_wdata <= i_req_wdata[int'(w_win)*XLEN +: XLEN];
      r_f3    <= i_req_f3[int'(w_win)*F3_W +: F3_W];
      r_wen   <= w_sel_wen;
      r_read  <= w_sel_read & ~w_sel_wen;
    end else if (r_state == ARB_BUSY && i_DM_data_ready) begin
      r_last  <= r_grant;
    end
  end

  assign o_rsp_rdata = i_DM_ReadData;

  // Shared-port drive and completion pulse; all quiet under reset.
  always_comb begin
    w_busy         = (r_state == ARB_BUSY) && !i_rst;
    o_DM_Addr      = i_rst ? '0 : r_addr;
    o_DM_WriteData = i_rst ? '0 : r_wdata;
    o_DM_f3        = i_rst ? '0 : r_f3;
    o_DM_MemRead   = w_busy && r_read;
    o_DM_Wen       = w_busy && r_wen;
    o_rsp_ready    = (w_busy && i_DM_data_ready) ? w_gsel : '0;
  end

endmodule

// File: tb/tb_hart_dm_arbiter.sv
// Randomised and directed bench for hart_dm_arbiter (NHARTS=4).
// Compares the DUT each cycle against a transaction-level model.
module tb_hart_dm_arbiter;

  localparam int NH = 4;
  localparam int XL = 32;

  typedef struct {
    int          hart;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  f3;
    bit          wr;
    int          cyc;
  } srv_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NH-1:0]    req_read;
  logic [NH-1:0]    req_wen;
  logic [NH*XL-1:0] req_addr;
  logic [NH*XL-1:0] req_wdata;
  logic [NH*3-1:0]  req_f3;
  logic [NH-1:0]    rsp_ready;
  logic [XL-1:0]    rsp_rdata;
  logic [XL-1:0]    dm_addr;
  logic [XL-1:0]    dm_wdata;
  logic [2:0]       dm_f3;
  logic             dm_rd;
  logic             dm_wen;
  logic             dm_ready;
  logic [XL-1:0]    dm_rdata;

  hart_dm_arbiter #(.NHARTS(NH), .XLEN(XL)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_read      (req_read),
    .i_req_wen       (req_wen),
    .i_req_addr      (req_addr),
    .i_req_wdata     (req_wdata),
    .i_req_f3        (req_f3),
    .o_rsp_ready     (rsp_ready),
    .o_rsp_rdata     (rsp_rdata),
    .o_DM_Addr       (dm_addr),
    .o_DM_WriteData  (dm_wdata),
    .o_DM_f3         (dm_f3),
    .o_DM_MemRead    (dm_rd),
    .o_DM_Wen        (dm_wen),
    .i_DM_data_ready (dm_ready),
    .i_DM_ReadData   (dm_rdata)
  );

  bit          h_rd [NH];
  bit          h_wen[NH];
  logic [31:0] h_addr[NH];
  logic [31:0] h_wdata[NH];
  logic [2:0]  h_f3[NH];

  bit          m_busy;
  int          m_hart;
  int          m_last;
  int          m_cnt;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [2:0]  m_f3;
  bit          m_rd;
  bit          m_wr;
  int          cyc;
  int          gcyc;
  srv_t        served[$];
  int          rdy_mode;
  int          pulses[NH];
  int          wen_cyc;
  int          rd_cyc;
  int          n_pass;
  int          n_total;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  task automatic apply();
    for (int h = 0; h < NH; h++) begin
      req_read[h] = h_rd[h];
      req_wen[h]  = h_wen[h];
      req_addr[h*XL +: XL]  = h_addr[h];
      req_wdata[h*XL +: XL] = h_wdata[h];
      req_f3[h*3 +: 3]      = h_f3[h];
    end
    case (rdy_mode)
      0:       dm_ready = 1'b0;
      1:       dm_ready = m_busy;
      2:       dm_ready = m_busy && (m_cnt >= 2);
      3:       dm_ready = 1'($urandom_range(0, 1));
      default: dm_ready = 1'b1;
    endcase
    if (m_addr == 32'h10)      dm_rdata = 32'h11111111;
    else if (m_addr == 32'h20) dm_rdata = 32'h22222222;
    else                       dm_rdata = $urandom;
  endtask

  task automatic check();
    logic [NH-1:0] e_rsp;
    bit            e_busy;
    e_busy = !rst && m_busy;
    e_rsp  = '0;
    if (e_busy && dm_ready) e_rsp[m_hart] = 1'b1;
    chk("rsp_ready", 64'(rsp_ready), 64'(e_rsp));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(dm_rdata));
    chk("dm_memread", 64'(dm_rd), 64'(e_busy && m_rd));
    chk("dm_wen", 64'(dm_wen), 64'(e_busy && m_wr));
    if (e_busy) begin
      chk("dm_addr", 64'(dm_addr), 64'(m_addr));
      chk("dm_wdata", 64'(dm_wdata), 64'(m_wdata));
      chk("dm_f3", 64'(dm_f3), 64'(m_f3));
    end
    if (rst) begin
      chk("rst_addr", 64'(dm_addr), 64'd0);
      chk("rst_wdata", 64'(dm_wdata), 64'd0);
      chk("rst_f3", 64'(dm_f3), 64'd0);
    end
    for (int h = 0; h < NH; h++)
      if (rsp_ready[h] === 1'b1) pulses[h]++;
    if (dm_wen === 1'b1) wen_cyc++;
    if (dm_rd === 1'b1)  rd_cyc++;
  endtask

  task automatic update();
    int win;
    cyc++;
    if (rst) begin
      m_busy = 0;
      m_last = NH - 1;
    end else if (m_busy) begin
      if (dm_ready) begin
        served.push_back('{hart: m_hart, addr: m_addr, wdata: m_wdata,
                           rdata: dm_rdata, f3: m_f3, wr: m_wr, cyc: cyc});
        h_rd[m_hart]  = 0;
        h_wen[m_hart] = 0;
        m_last = m_hart;
        m_busy = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      win = -1;
`ifdef HART_ARB_FIXED_PRIO_EN
      for (int k = 0; k < NH; k++)
        if (win < 0 && (h_rd[k] || h_wen[k])) win = k;
`else
      for (int k = 1; k <= NH; k++)
        if (win < 0 && (h_rd[(m_last+k)%NH] || h_wen[(m_last+k)%NH]))
          win = (m_last + k) % NH;
`endif
      if (win >= 0) begin
        m_busy  = 1;
        m_hart  = win;
        m_addr  = h_addr[win];
        m_wdata = h_wdata[win];
        m_f3    = h_f3[win];
        m_wr    = h_wen[win];
        m_rd    = h_rd[win] && !h_wen[win];
        m_cnt   = 0;
        gcyc    = cyc;
      end
    end
  endtask

  task automatic step();
    apply();
    @(negedge clk);
    check();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic run_until(int n, int maxs);
    int k = 0;
    while (served.size() < n && k < maxs) begin
      step();
      k++;
    end
    chk("bounded_wait", 64'(served.size() >= n), 64'd1);
  endtask

  task automatic clear_harts();
    for (int h = 0; h < NH; h++) begin
      h_rd[h] = 0; h_wen[h] = 0;
      h_addr[h] = '0; h_wdata[h] = '0; h_f3[h] = '0;
    end
  endtask

  task automatic clear_counts();
    served.delete();
    for (int h = 0; h < NH; h++) pulses[h] = 0;
    wen_cyc = 0;
    rd_cyc  = 0;
  endtask

  initial begin
    int pend;
    int k;
    n_pass = 0; n_total = 0; cyc = 0; gcyc = 0;
    m_busy = 0; m_last = NH - 1; m_cnt = 0; m_hart = 0;
    m_addr = '0; m_wdata = '0; m_f3 = '0; m_rd = 0; m_wr = 0;
    rdy_mode = 0;
    clear_harts();
    clear_counts();

    // Reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("post_rst_memread", 64'(dm_rd), 64'd0);

    // Single write from hart 1, memory ready two cycles after strobe
    clear_counts();
    rdy_mode = 2;
    h_wen[1] = 1; h_addr[1] = 32'h100;
    h_wdata[1] = 32'hDEADBEEF; h_f3[1] = 3'd2;
    run_until(1, 20);
    step(); step(); step();
    chk("w1_hart", 64'(served[0].hart), 64'd1);
    chk("w1_addr", 64'(served[0].addr), 64'h100);
    chk("w1_wdata", 64'(served[0].wdata), 64'hDEADBEEF);
    chk("w1_wr", 64'(served[0].wr), 64'd1);
    chk("w1_latency", 64'(served[0].cyc - gcyc), 64'd3);
    chk("w1_pulses_h1", 64'(pulses[1]), 64'd1);
    chk("w1_pulses_h0", 64'(pulses[0]), 64'd0);

    // Simultaneous loads from harts 0 and 1
    clear_counts();
    rdy_mode = 1;
    h_rd[0] = 1; h_addr[0] = 32'h10; h_f3[0] = 3'd2;
    h_rd[1] = 1; h_addr[1] = 32'h20; h_f3[1] = 3'd2;
    run_until(2, 30);
    chk("sim_first", 64'(served[0].hart), 64'd0);
    chk("sim_rdata0", 64'(served[0].rdata), 64'h11111111);
    chk("sim_second", 64'(served[1].hart), 64'd1);
    chk("sim_rdata1", 64'(served[1].rdata), 64'h22222222);

    // Fairness: all harts requesting continuously, immediate ready
    clear_harts();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_counts();
    rdy_mode = 1;
    k = 0;
    while (served.size() < 8 && k < 100) begin
      for (int h = 0; h < NH; h++)
        if (!h_rd[h] && !h_wen[h]) begin
          h_rd[h] = 1; h_addr[h] = 32'h1000 + 32'(h * 16);
        end
      step();
      k++;
    end
    chk("fair_bounded", 64'(served.size() >= 8), 64'd1);
    for (int i = 0; i < 8; i++) begin
`ifdef HART_ARB_FIXED_PRIO_EN
      chk("fair_order", 64'(served[i].hart), 64'd0);
`else
      chk("fair_order", 64'(served[i].hart), 64'(i % NH));
`endif
      if (i > 0)
        chk("fair_gap", 64'(served[i].cyc - served[i-1].cyc), 64'd2);
    end

    // Reset in the middle of an access
    clear_harts();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_counts();
    rdy_mode = 0;
    h_rd[0] = 1; h_addr[0] = 32'h40;
    h_rd[1] = 1; h_addr[1] = 32'h80;
    step(); step(); step();
    chk("mid_memread_busy", 64'(dm_rd), 64'd1);
    rst = 1'b1;
    rdy_mode = 4;
    step();
    rst = 1'b0;
    step();
    chk("mid_no_pulse", 64'(pulses[0] + pulses[1]), 64'd0);
    chk("mid_served", 64'(served.size()), 64'd0);
    rdy_mode = 1;
    run_until(2, 30);
    chk("mid_next_h0", 64'(served[0].hart), 64'd0);
    chk("mid_then_h1", 64'(served[1].hart), 64'd1);

    // Read and write raised together: write wins
    clear_harts();
    clear_counts();
    step();
    rdy_mode = 2;
    h_rd[0] = 1; h_wen[0] = 1;
    h_addr[0] = 32'h200; h_wdata[0] = 32'h5A5A5A5A;
    run_until(1, 20);
    chk("rw_wr", 64'(served[0].wr), 64'd1);
    chk("rw_wen_cycles", 64'(wen_cyc), 64'd3);
    chk("rw_rd_cycles", 64'(rd_cyc), 64'd0);

    // Random traffic
    rdy_mode = 3;
    for (int c = 0; c < 600; c++) begin
      for (int h = 0; h < NH; h++)
        if (!h_rd[h] && !h_wen[h] && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 3))
            0:       begin h_rd[h] = 1; h_wen[h] = 0; end
            1:       begin h_rd[h] = 0; h_wen[h] = 1; end
            2:       begin h_rd[h] = 1; h_wen[h] = 1; end
            default: begin h_rd[h] = 1; h_wen[h] = 0; end
          endcase
          h_addr[h]  = $urandom;
          h_wdata[h] = $urandom;
          h_f3[h]    = 3'($urandom_range(0, 7));
        end
      step();
    end

    // Drain outstanding requests
    rdy_mode = 1;
    k = 0;
    pend = 1;
    while (pend != 0 && k < 60) begin
      step();
      k++;
      pend = 0;
      for (int h = 0; h < NH; h++) pend += int'(h_rd[h] || h_wen[h]);
    end
    chk("drain", 64'(pend), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
